// File: rtl/branch_pkg.sv
// branch_pkg: shared constants and types for the branch predict/resolve unit.
//   OP_*        : RV32 opcodes that reach the branch unit
//   funct3_e    : conditional-branch comparison selectors
//   ctr_t       : 2-bit saturating direction counter
//   btb_entry_t : BTB line layout for the default 32-bit, 64-entry geometry
package branch_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET    = 2'b01;
  localparam ctr_t CTR_ALLOC_BR = 2'b10;
  localparam ctr_t CTR_MAX      = 2'b11;
  localparam ctr_t CTR_MIN      = 2'b00;

  localparam int unsigned BTB_XLEN  = 32;
  localparam int unsigned BTB_IDX_W = 6;

  typedef struct packed {
    logic                          valid;
    logic [BTB_XLEN-BTB_IDX_W-3:0] tag;
    ctr_t                          ctr;
    logic [BTB_XLEN-1:0]           target;
  } btb_entry_t;

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational conditional-branch evaluation.
//   funct3       in  3     comparison selector (unknown encodings -> not taken)
//   src_a, src_b in  XLEN  operands
//   cond         out 1     condition result
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (src_a == src_b);
      F3_BNE:  cond = (src_a != src_b);
      F3_BLT:  cond = ($signed(src_a) <  $signed(src_b));
      F3_BGE:  cond = ($signed(src_a) >= $signed(src_b));
      F3_BLTU: cond = (src_a <  src_b);
      F3_BGEU: cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch/jump resolution with a direct-mapped
// BTB (2-bit counters) for fetch prediction, registered redirect and
// saturating performance counters.
//   clk, rst_n                 clock / synchronous active-low reset
//   if_pc                      fetch lookup PC
//   pred_taken, pred_target    combinational prediction for if_pc
//   ex_*                       EX-stage instruction, operands and piped prediction
//   stall                      freezes resolve/update
//   redirect, redirect_pc      registered flush pulse and correct next PC
//   perf_branches/mispredicts  saturating event counters
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic              stall,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic [2:0]        ex_funct3,
  input  logic [6:0]        ex_opcode,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_pc_plus4,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [XLEN-1:0]   ex_srcA,
  input  logic [XLEN-1:0]   ex_srcB,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    ctr_t              ctr;
    logic [XLEN-1:0]   target;
  } btb_line_t;

  btb_line_t btb [ENTRIES];

  // Fetch-side lookup straight from the registered array.
  logic [IDX_W-1:0] lk_idx;
  btb_line_t        lk_line;
  logic             unused_lsbs;

  assign lk_idx      = if_pc[IDX_W+1:2];
  assign lk_line     = btb[lk_idx];
  assign pred_taken  = lk_line.valid && (lk_line.tag == if_pc[XLEN-1:IDX_W+2]) && lk_line.ctr[1];
  assign pred_target = pred_taken ? lk_line.target : '0;
  assign unused_lsbs = ^if_pc[1:0];

  // Resolve-side evaluation.
  logic            cond;
  logic            is_bj;
  logic            is_jalr;
  logic            act_taken;
  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] correct_pc;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (ex_funct3),
    .src_a  (ex_srcA),
    .src_b  (ex_srcB),
    .cond   (cond)
  );

  assign is_bj      = ex_branch | ex_jump;
  assign is_jalr    = ex_jump && (ex_opcode == OP_JALR);
  assign jalr_sum   = ex_srcA + ex_imm;
  assign target     = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
  assign act_taken  = ex_jump | (ex_branch & cond);
  assign resolve    = ex_valid & ~stall & ~redirect;
  assign correct_pc = act_taken ? target : ex_pc_plus4;

  // A predicted-taken non-branch means the BTB aliased onto it.
  assign mispredict = resolve &&
                      (is_bj ? ((ex_pred_taken != act_taken) ||
                                (act_taken && (ex_pred_target != target)))
                             : ex_pred_taken);

  // BTB update computed as a whole replacement line for the EX index.
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  btb_line_t        ex_line;
  logic             ex_hit;
  logic             upd_en;
  btb_line_t        upd_line;

  assign ex_idx  = ex_pc[IDX_W+1:2];
  assign ex_tag  = ex_pc[XLEN-1:IDX_W+2];
  assign ex_line = btb[ex_idx];
  assign ex_hit  = ex_line.valid && (ex_line.tag == ex_tag);

  always_comb begin
    upd_en   = 1'b0;
    upd_line = ex_line;
    if (resolve && is_bj) begin
      if (ex_hit) begin
        upd_en = 1'b1;
        if (ex_jump) begin
          upd_line.ctr    = CTR_MAX;
          upd_line.target = target;
        end else if (act_taken) begin
          if (ex_line.ctr != CTR_MAX) upd_line.ctr = ex_line.ctr + 2'd1;
          upd_line.target = target;
        end else if (ex_line.ctr != CTR_MIN) begin
          upd_line.ctr = ex_line.ctr - 2'd1;
        end
      end else if (act_taken) begin
        upd_en          = 1'b1;
        upd_line.valid  = 1'b1;
        upd_line.tag    = ex_tag;
        upd_line.ctr    = ex_jump ? CTR_MAX : CTR_ALLOC_BR;
        upd_line.target = target;
      end
    end else if (resolve && ex_pred_taken && (ex_line.tag == ex_tag)) begin
      upd_en         = 1'b1;
      upd_line.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb[IDX_W'(i)].valid  <= 1'b0;
        btb[IDX_W'(i)].tag    <= '0;
        btb[IDX_W'(i)].ctr    <= CTR_RESET;
        btb[IDX_W'(i)].target <= '0;
      end
      redirect         <= 1'b0;
      redirect_pc      <= '0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd_en) btb[ex_idx] <= upd_line;
      // mispredict already excludes the redirect cycle, so this is a one-cycle pulse.
      redirect <= mispredict;
      if (mispredict) redirect_pc <= correct_pc;
      if (resolve && is_bj && (perf_branches != '1))
        perf_branches <= perf_branches + PERF_W'(1);
      if (mispredict && (perf_mispredicts != '1))
        perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end

endmodule
